// File: rtl/dual_port_bram_param_if.sv
// Dual-port BRAM access bundle: two full read/write ports plus collision flag.
// Master drives requests, slave (the RAM) returns read data, valids and coll.
interface dual_port_bram_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    localparam int BE_W = DATA_W / 8;

    logic              en1;
    logic [BE_W-1:0]   we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] DI1;
    logic [DATA_W-1:0] DO1;
    logic              vld1;

    logic              en2;
    logic [BE_W-1:0]   we2;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] DI2;
    logic [DATA_W-1:0] DO2;
    logic              vld2;

    logic              coll;

    modport master (
        output en1, we1, addr1, DI1,
        output en2, we2, addr2, DI2,
        input  DO1, vld1, DO2, vld2, coll
    );

    modport slave (
        input  en1, we1, addr1, DI1,
        input  en2, we2, addr2, DI2,
        output DO1, vld1, DO2, vld2, coll
    );
endinterface

// File: rtl/dual_port_bram_param.sv
// True dual-port RAM with byte enables, per-port read-during-write mode,
// optional output register and prioritised same-address write merging.
module dual_port_bram_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int MODE1    = 0,
    parameter int MODE2    = 0,
    parameter int OUT_REG  = 0,
    parameter int PRIORITY = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    dual_port_bram_param_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_coll;
    logic [BE_W-1:0]   w_wr1;
    logic [BE_W-1:0]   w_wr2;
    logic [DATA_W-1:0] w_old1;
    logic [DATA_W-1:0] w_old2;
    logic [DATA_W-1:0] w_post1;
    logic [DATA_W-1:0] w_post2;
    logic              w_rd1;
    logic              w_rd2;

    logic [DATA_W-1:0] r_do1;
    logic [DATA_W-1:0] r_do2;
    logic              r_v1;
    logic              r_v2;
    logic              r_coll;

    assign w_coll = bus.en1 && bus.en2 && (bus.addr1 == bus.addr2);

    // Losing port drops lanes the winner also writes, so lane writes never overlap.
    always_comb begin
        w_wr1 = bus.en1 ? bus.we1 : '0;
        w_wr2 = bus.en2 ? bus.we2 : '0;
        if (w_coll) begin
            if (PRIORITY == 2) begin
                w_wr1 = w_wr1 & ~w_wr2;
            end else begin
                w_wr2 = w_wr2 & ~w_wr1;
            end
        end
    end

    assign w_old1 = r_mem[bus.addr1];
    assign w_old2 = r_mem[bus.addr2];

    always_comb begin
        w_post1 = w_old1;
        w_post2 = w_old2;
        for (int i = 0; i < BE_W; i++) begin
            if (w_wr1[i]) begin
                w_post1[8*i +: 8] = bus.DI1[8*i +: 8];
            end else if (w_coll && w_wr2[i]) begin
                w_post1[8*i +: 8] = bus.DI2[8*i +: 8];
            end
            if (w_wr2[i]) begin
                w_post2[8*i +: 8] = bus.DI2[8*i +: 8];
            end else if (w_coll && w_wr1[i]) begin
                w_post2[8*i +: 8] = bus.DI1[8*i +: 8];
            end
        end
    end

    // Array content survives reset; reset only blocks writes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (RST_N) begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_wr1[i]) begin
                    r_mem[bus.addr1][8*i +: 8] <= bus.DI1[8*i +: 8];
                end
                if (w_wr2[i]) begin
                    r_mem[bus.addr2][8*i +: 8] <= bus.DI2[8*i +: 8];
                end
            end
        end
    end

    assign w_rd1 = bus.en1 && !(MODE1 == 2 && bus.we1 != '0);
    assign w_rd2 = bus.en2 && !(MODE2 == 2 && bus.we2 != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_do1  <= '0;
            r_do2  <= '0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_v1   <= w_rd1;
            r_v2   <= w_rd2;
            r_coll <= w_coll && ((|bus.we1) || (|bus.we2));
            if (w_rd1) begin
                r_do1 <= (MODE1 == 1) ? w_post1 : w_old1;
            end
            if (w_rd2) begin
                r_do2 <= (MODE2 == 1) ? w_post2 : w_old2;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_do1_q;
            logic [DATA_W-1:0] r_do2_q;
            logic              r_v1_q;
            logic              r_v2_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_do1_q <= '0;
                    r_do2_q <= '0;
                    r_v1_q  <= 1'b0;
                    r_v2_q  <= 1'b0;
                end else begin
                    r_v1_q <= r_v1;
                    r_v2_q <= r_v2;
                    if (r_v1) begin
                        r_do1_q <= r_do1;
                    end
                    if (r_v2) begin
                        r_do2_q <= r_do2;
                    end
                end
            end

            assign bus.DO1  = r_do1_q;
            assign bus.DO2  = r_do2_q;
            assign bus.vld1 = r_v1_q;
            assign bus.vld2 = r_v2_q;
        end else begin : g_noreg
            assign bus.DO1  = r_do1;
            assign bus.DO2  = r_do2;
            assign bus.vld1 = r_v1;
            assign bus.vld2 = r_v2;
        end
    endgenerate

    assign bus.coll = r_coll;
endmodule
